// File: rtl/eqed_inject_sched.sv
// E-QED run-level injection scheduler.
// Clears and enables the MISRs, flips one flip-flop for a single cycle on the chosen run cycle,
// keeps the MISRs enabled for a capture window, and then pulses done.
// Optional feature macro: EQED_SIG_CHECK_EN. When it is defined, the signature inputs and a
// registered match result are added. When it is undefined, match_o is tied to 0.
module eqed_inject_sched #(
  parameter int unsigned NUM_FF = 8,
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned CNT_W  = 10,
  parameter int unsigned WINDOW = 5,
  parameter int unsigned MISR_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [SEL_W-1:0]  ff_idx_i,
  input  logic [CNT_W-1:0]  inj_cycle_i,
  input  logic [NUM_FF-1:0] ff_mask_i,
  output logic [NUM_FF-1:0] eqed_sel_o,
  output logic              misr_clr_o,
  output logic              misr_en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              rejected_o,
  output logic              injected_o,
  output logic [CNT_W-1:0]  cycle_count_o,
`ifdef EQED_SIG_CHECK_EN
  input  logic [MISR_W-1:0] in_sig_i,
  input  logic [MISR_W-1:0] out_sig_i,
  input  logic [MISR_W-1:0] exp_in_sig_i,
  input  logic [MISR_W-1:0] exp_out_sig_i,
`endif
  output logic              match_o
);

  localparam int unsigned WinW = (WINDOW < 2) ? 1 : $clog2(WINDOW + 1);
  localparam logic [SEL_W-1:0] NumFfSel = SEL_W'(NUM_FF);

  typedef enum logic [2:0] {StIdle, StReject, StClear, StArm, StCapture, StDone} state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  inj_q, inj_d;
  logic              masked_q, masked_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              injected_q, injected_d;
  logic [WinW-1:0]   win_q, win_d;
  logic              match_q, match_d;

  logic [NUM_FF-1:0] mask_shift;
  logic              req_in_range;
  logic              req_masked;
  logic              hit;
  logic [CNT_W-1:0]  cnt_inc;

  // Request decode: an index at or above NUM_FF is a golden run and is never masked.
  always_comb begin
    mask_shift   = ff_mask_i >> ff_idx_i;
    req_in_range = (ff_idx_i < NumFfSel);
    req_masked   = req_in_range & mask_shift[0];
    hit          = (idx_q < NumFfSel) & ~masked_q;
    cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    inj_d      = inj_q;
    masked_d   = masked_q;
    cnt_d      = cnt_q;
    injected_d = injected_q;
    win_d      = win_q;
    match_d    = match_q;
    eqed_sel_o = '0;
    misr_clr_o = 1'b0;
    misr_en_o  = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    rejected_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          idx_d    = ff_idx_i;
          inj_d    = (inj_cycle_i == '0) ? CNT_W'(1) : inj_cycle_i;
          masked_d = req_masked;
          state_d  = req_masked ? StReject : StClear;
        end
      end
      StReject: begin
        rejected_o = 1'b1;
        state_d    = StIdle;
      end
      StClear: begin
        misr_clr_o = 1'b1;
        busy_o     = 1'b1;
        cnt_d      = CNT_W'(1);
        injected_d = 1'b0;
        match_d    = 1'b0;
        state_d    = StArm;
      end
      StArm: begin
        misr_en_o = 1'b1;
        busy_o    = 1'b1;
        cnt_d     = cnt_inc;
        if (cnt_q == inj_q) begin
          if (hit) begin
            eqed_sel_o = NUM_FF'(1) << idx_q;
          end
          injected_d = injected_q | hit;
          win_d      = WinW'(WINDOW);
          state_d    = StCapture;
        end
      end
      StCapture: begin
        misr_en_o = 1'b1;
        busy_o    = 1'b1;
        cnt_d     = cnt_inc;
        if (win_q == WinW'(1)) begin
`ifdef EQED_SIG_CHECK_EN
          match_d = (in_sig_i == exp_in_sig_i) && (out_sig_i == exp_out_sig_i);
`endif
          state_d = StDone;
        end else begin
          win_d = win_q - WinW'(1);
        end
      end
      StDone: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // The flip select must never reach the design muxes while reset is asserted.
    if (rst_i) begin
      eqed_sel_o = '0;
    end
  end

  // State and latched-field registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      inj_q      <= '0;
      masked_q   <= 1'b0;
      cnt_q      <= '0;
      injected_q <= 1'b0;
      win_q      <= '0;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      inj_q      <= inj_d;
      masked_q   <= masked_d;
      cnt_q      <= cnt_d;
      injected_q <= injected_d;
      win_q      <= win_d;
      match_q    <= match_d;
    end
  end

  assign injected_o    = injected_q;
  assign cycle_count_o = cnt_q;
`ifdef EQED_SIG_CHECK_EN
  assign match_o = match_q;
`else
  assign match_o = 1'b0;
`endif

endmodule

// File: tb/tb_eqed_inject_sched.sv
// Self-checking bench for eqed_inject_sched: directed scenarios plus randomized runs,
// compared per cycle against a trace model built from the run timeline.
module tb_eqed_inject_sched;

  localparam int W = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] ff_idx;
  logic [9:0] inj_cycle;
  logic [7:0] ff_mask;
  logic [7:0] eqed_sel;
  logic       misr_clr, misr_en, busy, done, rejected, injected, match;
  logic [9:0] cycle_count;
`ifdef EQED_SIG_CHECK_EN
  logic [5:0] in_sig, out_sig, exp_in_sig, exp_out_sig;
`endif

  int checks   = 0;
  int failures = 0;

  // Model history carried between runs (values visible before the next CLEAR takes effect).
  int prev_cnt = 0;
  bit prev_inj = 0;
  bit prev_match = 0;

  logic [24:0] obs [64];

  eqed_inject_sched dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .ff_idx_i     (ff_idx),
    .inj_cycle_i  (inj_cycle),
    .ff_mask_i    (ff_mask),
    .eqed_sel_o   (eqed_sel),
    .misr_clr_o   (misr_clr),
    .misr_en_o    (misr_en),
    .busy_o       (busy),
    .done_o       (done),
    .rejected_o   (rejected),
    .injected_o   (injected),
    .cycle_count_o(cycle_count),
`ifdef EQED_SIG_CHECK_EN
    .in_sig_i     (in_sig),
    .out_sig_i    (out_sig),
    .exp_in_sig_i (exp_in_sig),
    .exp_out_sig_i(exp_out_sig),
`endif
    .match_o      (match)
  );

  always #5 clk = ~clk;

  // Bit layout: match, rejected, clr, en, busy, done, injected, sel[7:0], count[9:0].
  function automatic logic [24:0] pack_obs();
    return {match, rejected, misr_clr, misr_en, busy, done, injected, eqed_sel, cycle_count};
  endfunction

  function automatic logic [24:0] mk(bit mt, bit rj, bit cl, bit en, bit bs, bit dn, bit ij,
                                     logic [7:0] sel, int cnt);
    return {mt, rj, cl, en, bs, dn, ij, sel, 10'(cnt)};
  endfunction

  function automatic bit sig_ok();
`ifdef EQED_SIG_CHECK_EN
    return (in_sig == exp_in_sig) && (out_sig == exp_out_sig);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit is_rejected(int idx, logic [7:0] mask);
    logic [7:0] s;
    s = mask >> idx;
    return (idx < 8) && s[0];
  endfunction

  function automatic int eff_inj(int inj);
    return (inj == 0) ? 1 : inj;
  endfunction

  function automatic int run_len(int idx, int inj, logic [7:0] mask);
    return is_rejected(idx, mask) ? 3 : eff_inj(inj) + W + 3;
  endfunction

  // Expected outputs t cycles after the start edge: CLEAR at t=0, ARM for cycles 1..e,
  // CAPTURE for the next W cycles, DONE once, then IDLE.
  function automatic logic [24:0] exp_at(int t, int idx, int inj, logic [7:0] mask, bit m);
    int e;
    int last;
    bit hit;
    logic [7:0] sel;
    e    = eff_inj(inj);
    last = e + W + 1;
    hit  = (idx < 8);
    if (is_rejected(idx, mask))
      return mk(prev_match, t == 0, 0, 0, 0, 0, prev_inj, 8'h00, prev_cnt);
    if (t == 0) return mk(prev_match, 0, 1, 0, 1, 0, prev_inj, 8'h00, prev_cnt);
    if (t <= e) begin
      sel = (t == e && hit) ? (8'h01 << idx) : 8'h00;
      return mk(0, 0, 0, 1, 1, 0, 0, sel, t);
    end
    if (t <= e + W) return mk(0, 0, 0, 1, 1, 0, hit, 8'h00, t);
    if (t == last) return mk(m, 0, 0, 0, 1, 1, hit, 8'h00, t);
    return mk(m, 0, 0, 0, 0, 0, hit, 8'h00, last);
  endfunction

  task automatic model_commit(int idx, int inj, logic [7:0] mask, bit m);
    if (!is_rejected(idx, mask)) begin
      prev_cnt   = eff_inj(inj) + W + 1;
      prev_inj   = (idx < 8);
      prev_match = m;
    end
  endtask

  // Issues one start and records n cycles of outputs. With noise, request inputs and start
  // are scrambled while the run is busy; the scheduler must ignore them.
  task automatic do_run(int idx, int inj, logic [7:0] mask, bit noise, int n);
    @(negedge clk);
    start     = 1'b1;
    ff_idx    = 4'(idx);
    inj_cycle = 10'(inj);
    ff_mask   = mask;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      obs[t] = pack_obs();
      if (noise && t < n - 2) begin
        start     = 1'($urandom);
        ff_idx    = 4'($urandom);
        inj_cycle = 10'($urandom_range(0, 20));
        ff_mask   = 8'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ff_idx = '0; inj_cycle = '0; ff_mask = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (pack_obs() !== 25'h0) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", pack_obs(), 25'h0);
    end
    // Start coincident with reset must be ignored.
    start = 1'b1; ff_idx = 4'd2; inj_cycle = 10'd3;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checks++;
    if (pack_obs() !== 25'h0) begin
      failures++; $display("FAIL start_in_reset got=%h exp=%h", pack_obs(), 25'h0);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL start_in_reset_busy got=%b exp=0", busy);
    end
    prev_cnt = 0; prev_inj = 0; prev_match = 0;
  endtask

  task automatic test_golden();
    int n; int en_cnt; int clr_cnt; logic [24:0] ex; bit m;
    m = sig_ok();
    n = run_len(8, 3, 8'h00);
    do_run(8, 3, 8'h00, 1'b0, n);
    en_cnt = 0; clr_cnt = 0;
    for (int t = 0; t < n; t++) begin
      ex = exp_at(t, 8, 3, 8'h00, m);
      checks++;
      if (obs[t] !== ex) begin
        failures++; $display("FAIL golden cyc=%0d got=%h exp=%h", t, obs[t], ex);
      end
      en_cnt  += int'(obs[t][21]);
      clr_cnt += int'(obs[t][22]);
    end
    checks++;
    if (en_cnt != 8) begin
      failures++; $display("FAIL golden_en_cycles got=%0d exp=8", en_cnt);
    end
    checks++;
    if (clr_cnt != 1) begin
      failures++; $display("FAIL golden_clr_cycles got=%0d exp=1", clr_cnt);
    end
    model_commit(8, 3, 8'h00, m);
  endtask

  task automatic test_flip();
    int n; logic [24:0] ex; bit m;
    m = sig_ok();
    n = run_len(5, 4, 8'h00);
    do_run(5, 4, 8'h00, 1'b0, n);
    for (int t = 0; t < n; t++) begin
      ex = exp_at(t, 5, 4, 8'h00, m);
      checks++;
      if (obs[t] !== ex) begin
        failures++; $display("FAIL flip cyc=%0d got=%h exp=%h", t, obs[t], ex);
      end
    end
    checks++;
    if (obs[4][17:10] !== 8'b0010_0000 || obs[4][9:0] !== 10'd4) begin
      failures++;
      $display("FAIL flip_sel got=%b/%0d exp=00100000/4", obs[4][17:10], obs[4][9:0]);
    end
    model_commit(5, 4, 8'h00, m);
  endtask

  task automatic test_masked();
    int n; logic [24:0] ex; int busy_seen;
    n = run_len(6, 3, 8'b0100_0000);
    do_run(6, 3, 8'b0100_0000, 1'b0, n);
    busy_seen = 0;
    for (int t = 0; t < n; t++) begin
      ex = exp_at(t, 6, 3, 8'b0100_0000, 1'b0);
      checks++;
      if (obs[t] !== ex) begin
        failures++; $display("FAIL masked cyc=%0d got=%h exp=%h", t, obs[t], ex);
      end
      busy_seen += int'(obs[t][20]);
    end
    checks++;
    if (busy_seen != 0) begin
      failures++; $display("FAIL masked_busy got=%0d exp=0", busy_seen);
    end
  endtask

  task automatic test_inj_zero();
    int n; logic [24:0] ex; bit m;
    m = sig_ok();
    n = run_len(0, 0, 8'h00);
    do_run(0, 0, 8'h00, 1'b0, n);
    for (int t = 0; t < n; t++) begin
      ex = exp_at(t, 0, 0, 8'h00, m);
      checks++;
      if (obs[t] !== ex) begin
        failures++; $display("FAIL inj_zero cyc=%0d got=%h exp=%h", t, obs[t], ex);
      end
    end
    checks++;
    if (obs[1][17:10] !== 8'b0000_0001) begin
      failures++; $display("FAIL inj_zero_sel got=%b exp=00000001", obs[1][17:10]);
    end
    model_commit(0, 0, 8'h00, m);
  endtask

  task automatic test_reset_mid_run();
    int n; logic [24:0] ex; int done_seen; bit m;
    // Reset asserted in the injection cycle gates the select immediately.
    @(negedge clk);
    start = 1'b1; ff_idx = 4'd3; inj_cycle = 10'd4; ff_mask = 8'h00;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (eqed_sel !== 8'h08) begin
      failures++; $display("FAIL pre_reset_sel got=%b exp=00001000", eqed_sel);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (eqed_sel !== 8'h00) begin
      failures++; $display("FAIL sel_during_reset got=%b exp=00000000", eqed_sel);
    end
    @(negedge clk);
    rst = 1'b0;
    // Reset during CAPTURE: everything clears and no done follows.
    @(negedge clk);
    start = 1'b1; ff_idx = 4'd1; inj_cycle = 10'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (misr_en !== 1'b1 || cycle_count !== 10'd4) begin
      failures++; $display("FAIL capture_reached got=%b/%0d exp=1/4", misr_en, cycle_count);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (pack_obs() !== 25'h0) begin
      failures++; $display("FAIL mid_run_reset got=%h exp=%h", pack_obs(), 25'h0);
    end
    done_seen = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      done_seen += int'(done) + int'(busy);
    end
    checks++;
    if (done_seen != 0) begin
      failures++; $display("FAIL no_done_after_reset got=%0d exp=0", done_seen);
    end
    prev_cnt = 0; prev_inj = 0; prev_match = 0;
    m = sig_ok();
    n = run_len(7, 2, 8'h00);
    do_run(7, 2, 8'h00, 1'b0, n);
    for (int t = 0; t < n; t++) begin
      ex = exp_at(t, 7, 2, 8'h00, m);
      checks++;
      if (obs[t] !== ex) begin
        failures++; $display("FAIL after_reset cyc=%0d got=%h exp=%h", t, obs[t], ex);
      end
    end
    model_commit(7, 2, 8'h00, m);
  endtask

  task automatic test_random();
    int n; int idx; int inj; logic [7:0] mask; logic [24:0] ex; bit rj; bit m; int errs;
    for (int r = 0; r < 30; r++) begin
      idx  = $urandom_range(0, 9);
      inj  = $urandom_range(0, 12);
      mask = 8'($urandom);
`ifdef EQED_SIG_CHECK_EN
      in_sig      = 6'($urandom);
      out_sig     = 6'($urandom);
      exp_in_sig  = ($urandom_range(0, 3) != 0) ? in_sig : 6'($urandom);
      exp_out_sig = ($urandom_range(0, 3) != 0) ? out_sig : 6'($urandom);
`endif
      m  = sig_ok();
      rj = is_rejected(idx, mask);
      n  = run_len(idx, inj, mask);
      do_run(idx, inj, mask, !rj, n);
      errs = 0;
      for (int t = 0; t < n; t++) begin
        ex = exp_at(t, idx, inj, mask, m);
        checks++;
        if (obs[t] !== ex) begin
          failures++; errs++;
          if (errs <= 3)
            $display("FAIL random run=%0d idx=%0d inj=%0d mask=%h cyc=%0d got=%h exp=%h",
                     r, idx, inj, mask, t, obs[t], ex);
        end
      end
      model_commit(idx, inj, mask, m);
    end
  endtask

`ifdef EQED_SIG_CHECK_EN
  task automatic test_sig_check();
    int n; logic [24:0] ex; bit m;
    in_sig = 6'b111010; out_sig = 6'b110010;
    exp_in_sig = 6'b111010; exp_out_sig = 6'b110010;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) out_sig = 6'b110011;
      m = (k == 0);
      n = run_len(2, 3, 8'h00);
      do_run(2, 3, 8'h00, 1'b0, n);
      for (int t = 0; t < n; t++) begin
        ex = exp_at(t, 2, 3, 8'h00, m);
        checks++;
        if (obs[t] !== ex) begin
          failures++; $display("FAIL sig run=%0d cyc=%0d got=%h exp=%h", k, t, obs[t], ex);
        end
      end
      checks++;
      if (obs[n-2][24] !== m || obs[n-2][19] !== 1'b1) begin
        failures++;
        $display("FAIL sig_match run=%0d got=%b/done=%b exp=%b/1", k, obs[n-2][24],
                 obs[n-2][19], m);
      end
      model_commit(2, 3, 8'h00, m);
    end
  endtask
`endif

  initial begin
`ifdef EQED_SIG_CHECK_EN
    in_sig = '0; out_sig = '0; exp_in_sig = '0; exp_out_sig = '0;
`endif
    test_reset();
    test_golden();
    test_flip();
    test_masked();
    test_inj_zero();
    test_reset_mid_run();
`ifdef EQED_SIG_CHECK_EN
    test_sig_check();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eqed_inject_sched.md
Name: eqed_inject_sched

Overview:
- Run-level scheduler for E-QED single-cycle flip-flop bit-flip injection on a design module under check.
- Accepts a start request carrying a target FF index and an injection cycle. Clears and enables the input/output MISRs, and drives a one-hot flip select for exactly one cycle. It then holds the MISRs enabled for a fixed capture window and reports completion.
- Sits in the top-level E-QED wrapper in place of the free-running decoder, error-injected flag and cycle counter.

Parameters:
- NUM_FF, 8, number of injectable FFs (width of the one-hot select).
- SEL_W, 4, width of the FF index; must satisfy 2**SEL_W > NUM_FF.
- CNT_W, 10, width of the cycle counter and injection-cycle field.
- WINDOW, 5, capture-window length in cycles after the injection cycle; must be ≥1.
- MISR_W, 6, signature width (used only with the optional feature).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  run request, sampled only in IDLE.
- ff_idx  input  SEL_W  FF to flip; a value ≥ NUM_FF means golden run (no flip).
- inj_cycle  input  CNT_W  run cycle on which the flip is applied; 0 is treated as 1.
- ff_mask  input  NUM_FF  1 = candidate excluded; sampled with start.
- eqed_sel  output  NUM_FF  one-hot flip select to the design-module muxes.
- misr_clr  output  1  MISR synchronous clear.
- misr_en  output  1  MISR update enable.
- busy  output  1  high from CLEAR through DONE.
- done  output  1  one-cycle completion pulse.
- rejected  output  1  one-cycle pulse: start refused because the candidate is masked.
- injected  output  1  flip has been applied this run; sticky until next CLEAR.
- cycle_count  output  CNT_W  run cycle counter.
- in_sig  input  MISR_W  input-MISR value (feature only).
- out_sig  input  MISR_W  output-MISR value (feature only).
- exp_in_sig  input  MISR_W  expected input-MISR signature (feature only).
- exp_out_sig  input  MISR_W  expected output-MISR signature (feature only).
- match  output  1  signature comparison result (feature only).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, all outputs 0, cycle_count 0, latched fields 0.
- eqed_sel is forced to 0 in any cycle where rst is high.
- FSM states: IDLE, REJECT, CLEAR, ARM, CAPTURE, DONE.
- IDLE:
  - On start=1, latch ff_idx, inj_cycle (0→1) and ff_mask[ff_idx].
  - If ff_idx < NUM_FF and the mask bit is set, go to REJECT; otherwise go to CLEAR.
  - start is ignored in every other state; no queuing.
- REJECT: rejected=1 for one cycle, then IDLE. No MISR or select activity.
- CLEAR: one cycle.
  - misr_clr=1, misr_en=0.
  - Next cycle: cycle_count=1, injected=0, go to ARM.
- ARM:
  - misr_en=1; cycle_count increments each cycle, saturating at all-ones.
  - In the cycle where cycle_count == latched inj_cycle:
    - eqed_sel = one-hot(ff_idx) combinationally that cycle only, or all-zero for a golden run.
    - injected goes to 1 next cycle if a bit was driven.
    - Next state is CAPTURE with the window counter loaded to WINDOW.
  - If inj_cycle exceeds the saturated count, the run stays in ARM until reset. This is a documented limit; software keeps inj_cycle < 2**CNT_W - 1.
- CAPTURE:
  - misr_en=1, counter decrements; cycle_count keeps counting.
  - When the counter reaches 1, go to DONE.
  - Total MISR-enabled cycles after injection = WINDOW.
- DONE: misr_en=0, done=1 for one cycle, match valid this cycle, then IDLE.
- busy=1 in CLEAR, ARM, CAPTURE and DONE.
- Select invariant: at most one eqed_sel bit is high in any cycle, and for at most one cycle per run.
- Reset mid-run: return to IDLE next edge with all outputs 0. No done pulse.
- Start coincident with rst: ignored.

Optional Feature:
- Macro: EQED_SIG_CHECK_EN.
- Defined:
  - match is registered on entry to DONE as (in_sig == exp_in_sig) && (out_sig == exp_out_sig), sampled in the last CAPTURE cycle.
  - match holds until the next CLEAR.
- Undefined:
  - The signature ports are absent; match is tied to 0.

Test Plan:
- Golden run: ff_idx=8, inj_cycle=3, WINDOW=5, mask=0.
  - misr_clr one cycle; misr_en high 2+1+5=8 cycles; eqed_sel never nonzero; injected=0; done pulse.
- Flip FF 5 at cycle 4, mask=0.
  - eqed_sel=8'b0010_0000 only in the ARM cycle with cycle_count=4; injected=1 from next cycle; done after 5 CAPTURE cycles.
- Masked candidate: ff_mask=8'b0100_0000, ff_idx=6.
  - rejected pulse one cycle; busy never high; eqed_sel stays 0.
- inj_cycle=0, ff_idx=0.
  - Behaves as inj_cycle=1: eqed_sel=8'b0000_0001 in the first ARM cycle.
- Reset mid-run: assert rst during CAPTURE.
  - Next cycle all outputs 0, state IDLE, no done.
  - A second start with ff_idx=7, inj_cycle=2 completes normally.
- With EQED_SIG_CHECK_EN: drive in_sig=6'b111010, out_sig=6'b110010, expected values equal.
  - match=1 at DONE.
  - Change out_sig to 6'b110011 and rerun: match=0.
